inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch.sv | 79 +++++++
 tb/tb_inst_fetch.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch address generator with an in-order instruction queue toward decode
// Ports:
//   clk, rst (async, active-low)  clock / reset
//   rdy_in                        global ready; low freezes all state
//   pc_o                          fetch address to memory controller
//   pc_done_i, fetch_pc_i, inst_i completed fetch strobe, its address and word
//   br_flag_i, br_target_i        redirect request and target from execute
//   id_valid_o, id_inst_o, id_pc_o, id_ready_i  queue head handshake toward decode
// Define INST_FETCH_BYPASS_EN to forward an accepted word straight to decode when the queue is empty.
module inst_fetch #(
  parameter int          QUEUE_DEPTH = 4,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy_in,
  output logic [31:0] pc_o,
  input  logic        pc_done_i,
  input  logic [31:0] fetch_pc_i,
  input  logic [31:0] inst_i,
  input  logic        br_flag_i,
  input  logic [31:0] br_target_i,
  output logic        id_valid_o,
  output logic [31:0] id_inst_o,
  output logic [31:0] id_pc_o,
  input  logic        id_ready_i
);
  localparam int AW = $clog2(QUEUE_DEPTH);
  localparam logic [AW:0]   FULL = (AW+1)'(QUEUE_DEPTH);
  localparam logic [AW:0]   C1   = (AW+1)'(1);
  localparam logic [AW-1:0] P1   = AW'(1);
  logic [31:0] pc_q [QUEUE_DEPTH];
  logic [31:0] inst_q [QUEUE_DEPTH];
  logic [AW-1:0] head, tail;
  logic [AW:0] count;
  logic flush, accept, empty, take, push, pop;
  assign flush  = rdy_in & br_flag_i;
  // Full test looks at occupancy before any same-cycle pop; a refused word is simply refetched.
  assign accept = rdy_in & pc_done_i & ~br_flag_i & (fetch_pc_i == pc_o) & (count != FULL);
  assign empty  = count == '0;
  assign pop    = rdy_in & ~br_flag_i & ~empty & id_ready_i;
`ifdef INST_FETCH_BYPASS_EN
  // A bypassed word taken by decode this cycle never enters the queue.
  assign take       = accept & empty & id_ready_i;
  assign id_valid_o = ~empty | accept;
  assign id_inst_o  = ~empty ? inst_q[head] : accept ? inst_i : '0;
  assign id_pc_o    = ~empty ? pc_q[head] : accept ? fetch_pc_i : '0;
`else
  assign take       = 1'b0;
  assign id_valid_o = ~empty;
  assign id_inst_o  = empty ? '0 : inst_q[head];
  assign id_pc_o    = empty ? '0 : pc_q[head];
`endif
  assign push = accept & ~take;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o  <= RESET_PC;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (flush) begin
      pc_o  <= br_target_i;
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (accept) pc_o <= pc_o + 32'd4;
      if (push) tail <= tail + P1;
      if (pop) head <= head + P1;
      if (push != pop) count <= push ? count + C1 : count - C1;
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      pc_q[tail]   <= pc_o;
      inst_q[tail] <= inst_i;
    end
  end
endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed self-checking bench for inst_fetch
module tb_inst_fetch;
`ifdef INST_FETCH_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  logic clk, rst, rdy_in, pc_done_i, br_flag_i, id_ready_i, id_valid_o;
  logic [31:0] pc_o, fetch_pc_i, inst_i, br_target_i, id_inst_o, id_pc_o;
  int tests = 0, fails = 0;

  inst_fetch #(.QUEUE_DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy_in(rdy_in), .pc_o(pc_o), .pc_done_i(pc_done_i),
    .fetch_pc_i(fetch_pc_i), .inst_i(inst_i), .br_flag_i(br_flag_i), .br_target_i(br_target_i),
    .id_valid_o(id_valid_o), .id_inst_o(id_inst_o), .id_pc_o(id_pc_o), .id_ready_i(id_ready_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic head(input string tag, input logic v, input logic [31:0] p, input logic [31:0] i);
    chk({tag, "_valid"}, {31'b0, id_valid_o}, {31'b0, v});
    chk({tag, "_pc"}, id_pc_o, p);
    chk({tag, "_inst"}, id_inst_o, i);
  endtask

  function automatic logic [31:0] word(input logic [31:0] p);
    return 32'hA000_0000 | p;
  endfunction

  initial begin
    rst = 1'b1; rdy_in = 1'b1; pc_done_i = 1'b0; fetch_pc_i = '0; inst_i = '0;
    br_flag_i = 1'b0; br_target_i = '0; id_ready_i = 1'b0;
    #3 rst = 1'b0;
    #1;
    chk("rst_pc", pc_o, 32'h0);
    head("rst", 1'b0, 32'h0, 32'h0);
    tick(); tick();
    rst = 1'b1;
    // first fetch at RESET_PC
    pc_done_i = 1'b1; fetch_pc_i = 32'h0; inst_i = 32'h13;
    #1;
    head("pre_first", BYP, BYP ? 32'h0 : 32'h0, BYP ? 32'h13 : 32'h0);
    tick();
    chk("first_pc", pc_o, 32'h4);
    head("first", 1'b1, 32'h0, 32'h13);
    // fill the queue
    for (int i = 1; i < 4; i++) begin
      fetch_pc_i = 32'(4 * i); inst_i = word(32'(4 * i));
      tick();
    end
    chk("fill_pc", pc_o, 32'h10);
    fetch_pc_i = 32'h10; inst_i = word(32'h10);
    tick();
    chk("full_refuse_pc", pc_o, 32'h10);
    head("full_head", 1'b1, 32'h0, 32'h13);
    id_ready_i = 1'b1;
    tick();
    chk("full_poponly_pc", pc_o, 32'h10);
    head("full_poponly", 1'b1, 32'h4, word(32'h4));
    tick();
    chk("refetch_pc", pc_o, 32'h14);
    head("refetch", 1'b1, 32'h8, word(32'h8));
    pc_done_i = 1'b0;
    tick();
    head("drain_c", 1'b1, 32'hC, word(32'hC));
    tick();
    head("drain_10", 1'b1, 32'h10, word(32'h10));
    tick();
    head("drain_empty", 1'b0, 32'h0, 32'h0);
    id_ready_i = 1'b0;
    // three entries then redirect with a concurrent valid response
    pc_done_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc_i = 32'h14 + 32'(4 * i); inst_i = word(fetch_pc_i);
      tick();
    end
    chk("three_pc", pc_o, 32'h20);
    head("three", 1'b1, 32'h14, word(32'h14));
    fetch_pc_i = 32'h20; inst_i = word(32'h20);
    br_flag_i = 1'b1; br_target_i = 32'h200; id_ready_i = 1'b1;
    tick();
    chk("redir_pc", pc_o, 32'h200);
    head("redir", 1'b0, 32'h0, 32'h0);
    br_flag_i = 1'b0; id_ready_i = 1'b0; fetch_pc_i = 32'hC; inst_i = word(32'hC);
    tick();
    chk("stale_pc", pc_o, 32'h200);
    head("stale", 1'b0, 32'h0, 32'h0);
    // redirect held two cycles re-flushes each cycle
    br_flag_i = 1'b1; br_target_i = 32'h300; fetch_pc_i = 32'h200; inst_i = word(32'h200);
    tick();
    chk("hold1_pc", pc_o, 32'h300);
    fetch_pc_i = 32'h300; inst_i = word(32'h300);
    tick();
    chk("hold2_pc", pc_o, 32'h300);
    head("hold2", 1'b0, 32'h0, 32'h0);
    br_flag_i = 1'b0;
    tick();
    chk("resume_pc", pc_o, 32'h304);
    head("resume", 1'b1, 32'h300, word(32'h300));
    // global stall
    rdy_in = 1'b0; id_ready_i = 1'b1; fetch_pc_i = 32'h304; inst_i = word(32'h304);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_pc", pc_o, 32'h304);
      head("stall", 1'b1, 32'h300, word(32'h300));
    end
    rdy_in = 1'b1;
    tick();
    chk("unstall_pc", pc_o, 32'h308);
    head("unstall", 1'b1, 32'h304, word(32'h304));
    pc_done_i = 1'b0;
    tick();
    head("unstall_drain", 1'b0, 32'h0, 32'h0);
    id_ready_i = 1'b0;
    // address wrap
    br_flag_i = 1'b1; br_target_i = 32'hFFFF_FFFC;
    tick();
    chk("wrap_redir_pc", pc_o, 32'hFFFF_FFFC);
    br_flag_i = 1'b0; pc_done_i = 1'b1; fetch_pc_i = 32'hFFFF_FFFC; inst_i = 32'h1234_5678;
    tick();
    chk("wrap_pc", pc_o, 32'h0);
    head("wrap", 1'b1, 32'hFFFF_FFFC, 32'h1234_5678);
    // empty queue, decode ready, response at 0x40
    pc_done_i = 1'b0; br_flag_i = 1'b1; br_target_i = 32'h40;
    tick();
    chk("byp_redir_pc", pc_o, 32'h40);
    br_flag_i = 1'b0; id_ready_i = 1'b1; pc_done_i = 1'b1; fetch_pc_i = 32'h40; inst_i = word(32'h40);
    #1;
    head("byp_same", BYP, BYP ? 32'h40 : 32'h0, BYP ? word(32'h40) : 32'h0);
    tick();
    pc_done_i = 1'b0;
    #1;
    chk("byp_pc", pc_o, 32'h44);
    head("byp_next", !BYP, BYP ? 32'h0 : 32'h40, BYP ? 32'h0 : word(32'h40));
    tick();
    head("byp_end", 1'b0, 32'h0, 32'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
